// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes ALU requests, sequences the registered ALU and
// returns result/flags with the request tag. Option: ALU_ISSUE_STATS_EN.
module alu_issue_unit #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [5:0]       req_funct,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic [3:0]       alu_ctrl,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             rsp_overflow,
    output logic             rsp_illegal,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]      op_count,
    output logic [15:0]      ovf_count,
`endif
    output logic [TAG_W-1:0] rsp_tag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    logic             accept;
    logic             rsp_hs;

    logic [31:0]      src1_q, src2_q;
    logic [3:0]       ctrl_q;
    logic [31:0]      result_q;
    logic             zero_q, cout_q, ovf_q, illegal_q;
    logic [TAG_W-1:0] tag_q;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = req_valid & req_ready;
    assign rsp_hs    = rsp_valid & rsp_ready;

    // Translate ALUOp/funct into the ALU control code, flag anything unknown
    always_comb begin
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b0;
        unique case (req_aluop)
            2'b00: dec_ctrl = 4'b0010;
            2'b01: dec_ctrl = 4'b0110;
            2'b10: begin
                unique case (req_funct)
                    6'b100000: dec_ctrl = 4'b0010;
                    6'b100010: dec_ctrl = 4'b0110;
                    6'b100100: dec_ctrl = 4'b0000;
                    6'b100101: dec_ctrl = 4'b0001;
                    6'b100111: dec_ctrl = 4'b1100;
                    6'b101010: dec_ctrl = 4'b0111;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Next-state: illegal ops skip the ALU and answer immediately
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = dec_illegal ? RESP : ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU drive registers: only a legal accept updates them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src1_q <= '0;
            src2_q <= '0;
            ctrl_q <= '0;
        end else if (accept && !dec_illegal) begin
            src1_q <= req_a;
            src2_q <= req_b;
            ctrl_q <= dec_ctrl;
        end
    end

    // Response registers: tag on accept, ALU outputs in CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            tag_q     <= '0;
        end else if (accept) begin
            tag_q <= req_tag;
            if (dec_illegal) begin
                result_q  <= '0;
                zero_q    <= 1'b0;
                cout_q    <= 1'b0;
                ovf_q     <= 1'b0;
                illegal_q <= 1'b1;
            end
        end else if (state_q == CAPTURE) begin
            result_q  <= alu_result;
            zero_q    <= alu_zero;
            cout_q    <= alu_cout;
            ovf_q     <= alu_overflow;
            illegal_q <= 1'b0;
        end
    end

    assign alu_src1     = src1_q;
    assign alu_src2     = src2_q;
    assign alu_ctrl     = ctrl_q;
    assign rsp_result   = result_q;
    assign rsp_zero     = zero_q;
    assign rsp_cout     = cout_q;
    assign rsp_overflow = ovf_q;
    assign rsp_illegal  = illegal_q;
    assign rsp_tag      = tag_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_cnt_q, ovf_cnt_q;

    // Saturating counts of completed responses and overflowing ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            ovf_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (op_cnt_q != 16'hFFFF) begin
                op_cnt_q <= op_cnt_q + 16'd1;
            end
            if (ovf_q && ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end
    end

    assign op_count  = op_cnt_q;
    assign ovf_count = ovf_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: directed requests against a registered ALU model,
// responses checked by a scoreboard monitor.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_aluop = '0;
    logic [5:0]  req_funct = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero, alu_cout, alu_overflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_overflow, rsp_illegal;
    logic [3:0]  rsp_tag;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] op_count, ovf_count;
`endif

    alu_issue_unit #(.TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct(req_funct),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
        .rsp_illegal(rsp_illegal),
`ifdef ALU_ISSUE_STATS_EN
        .op_count(op_count), .ovf_count(ovf_count),
`endif
        .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    // Registered ALU model sharing rst_n with the unit
    always_ff @(posedge clk or negedge rst_n) begin
        logic [32:0] s;
        if (!rst_n) begin
            alu_result   <= '0;
            alu_zero     <= 1'b0;
            alu_cout     <= 1'b0;
            alu_overflow <= 1'b0;
        end else begin
            s = '0;
            alu_cout     <= 1'b0;
            alu_overflow <= 1'b0;
            case (alu_ctrl)
                4'b0010: begin
                    s = {1'b0, alu_src1} + {1'b0, alu_src2};
                    alu_cout <= s[32];
                    alu_overflow <= (alu_src1[31] == alu_src2[31]) &&
                                    (s[31] != alu_src1[31]);
                end
                4'b0110: begin
                    s = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
                    alu_cout <= s[32];
                    alu_overflow <= (alu_src1[31] != alu_src2[31]) &&
                                    (s[31] != alu_src1[31]);
                end
                4'b0000: s[31:0] = alu_src1 & alu_src2;
                4'b0001: s[31:0] = alu_src1 | alu_src2;
                4'b1100: s[31:0] = ~(alu_src1 | alu_src2);
                4'b0111: s[31:0] = {31'd0,
                    $signed(alu_src1) < $signed(alu_src2)};
                default: s = '0;
            endcase
            alu_result <= s[31:0];
            alu_zero   <= (s[31:0] == 32'd0);
        end
    end

    typedef struct {
        logic [31:0] r;
        logic        z, c, o, ill;
        logic [3:0]  tag;
        int          acc;
        int          lat;
        bit          seen;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic [3:0] last_ctrl = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: compares every RESP cycle against the head, pops on handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready && q.size() != 0)
                check("ready_while_pending", {31'd0, req_ready}, 32'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    if (!q[0].seen) begin
                        check("latency", cyc - q[0].acc, q[0].lat);
                        q[0].seen = 1'b1;
                    end
                    check("rsp_result", rsp_result, q[0].r);
                    check("rsp_flags",
                          {28'd0, rsp_zero, rsp_cout, rsp_overflow, rsp_illegal},
                          {28'd0, q[0].z, q[0].c, q[0].o, q[0].ill});
                    check("rsp_tag", {28'd0, rsp_tag}, {28'd0, q[0].tag});
                    check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                    if (rsp_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Issue one request; legal ones answer in the third cycle after accept
    task automatic send(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic [31:0] r,
                        input logic z, input logic c, input logic o,
                        input logic ill, input logic [3:0] ctrl);
        int n = 0;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_aluop = op;
        req_funct = fn;
        req_a = a;
        req_b = b;
        req_tag = tag;
        @(negedge clk);
        while (!req_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.r = r; e.z = z; e.c = c; e.o = o; e.ill = ill; e.tag = tag;
        e.acc = cyc + 1;
        e.lat = ill ? 0 : 2;
        e.seen = 1'b0;
        @(posedge clk);
        q.push_back(e);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (ill) begin
            check("ctrl_unchanged", {28'd0, alu_ctrl}, {28'd0, last_ctrl});
        end else begin
            check("issue_ctrl", {28'd0, alu_ctrl}, {28'd0, ctrl});
            check("issue_src1", alu_src1, a);
            check("issue_src2", alu_src2, b);
            last_ctrl = ctrl;
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({nm, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({nm, "_result"}, rsp_result, 32'd0);
        check({nm, "_flags"},
              {27'd0, rsp_zero, rsp_cout, rsp_overflow, rsp_illegal, 1'b0},
              32'd0);
        check({nm, "_tag"}, {28'd0, rsp_tag}, 32'd0);
        check({nm, "_alu_ops"}, alu_src1 | alu_src2 | {28'd0, alu_ctrl}, 32'd0);
`ifdef ALU_ISSUE_STATS_EN
        check({nm, "_counters"}, {op_count, ovf_count}, 32'd0);
`endif
    endtask

    task automatic drain;
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        if (q.size() != 0) begin
            check("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        send(2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, 4'h1,
             32'h80000000, 0, 0, 1, 0, 4'b0010);
        send(2'b01, 6'b000000, 32'd5, 32'd5, 4'h2,
             32'd0, 1, 1, 0, 0, 4'b0110);
        send(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 4'h3,
             32'd1, 0, 0, 0, 0, 4'b0111);
        send(2'b10, 6'b100111, 32'd0, 32'd0, 4'h4,
             32'hFFFFFFFF, 0, 0, 0, 0, 4'b1100);
        send(2'b10, 6'b000000, 32'h12345678, 32'h9, 4'hA,
             32'd0, 0, 0, 0, 1, 4'b0000);
        send(2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1, 4'h5,
             32'd0, 1, 1, 0, 0, 4'b0010);
        send(2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 4'h6,
             32'hF000F000, 0, 0, 0, 0, 4'b0000);
        send(2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0F0F0000, 4'h7,
             32'hFFFFF0F0, 0, 0, 0, 0, 4'b0001);
        send(2'b10, 6'b100010, 32'h80000000, 32'd1, 4'h8,
             32'h7FFFFFFF, 0, 1, 1, 0, 4'b0110);
        send(2'b11, 6'b100000, 32'd1, 32'd1, 4'h3,
             32'd0, 0, 0, 0, 1, 4'b0110);
        drain();

        // Back-pressure: response must hold for five stalled cycles
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(2'b00, 6'b000000, 32'd3, 32'd4, 4'hB,
             32'd7, 0, 0, 0, 0, 4'b0010);
        n = 0;
        while (!rsp_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(2'b01, 6'b000000, 32'd10, 32'd3, 4'hC,
             32'd7, 0, 1, 0, 0, 4'b0110);
        send(2'b10, 6'b100101, 32'h1, 32'h2, 4'hD,
             32'd3, 0, 0, 0, 0, 4'b0001);
        drain();

        // Reset while the op sits in CAPTURE drops it entirely
        send(2'b00, 6'b000000, 32'd1, 32'd1, 4'hE,
             32'd2, 0, 0, 0, 0, 4'b0010);
        @(posedge clk); #2;
        rst_n = 1'b0;
        q.delete();
        last_ctrl = 4'b0000;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("post_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
